// File: rtl/alu_share_pkg.sv
// alu_share_pkg
//   Shared types for the ALU sharing controller: the ALU operation
//   encoding, the controller state enum and helpers for shift masking.
package alu_share_pkg;

    typedef enum logic [3:0] {
        AddOp  = 4'd0,
        SubOp  = 4'd1,
        AndOp  = 4'd2,
        OrOp   = 4'd3,
        XorOp  = 4'd4,
        SllOp  = 4'd5,
        SrlOp  = 4'd6,
        SraOp  = 4'd7,
        SltOp  = 4'd8,
        SltuOp = 4'd9
    } ALU_Ops;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ShareState;

    // Mask that keeps only the shift-amount bits of an operand (RISC-V shamt).
    function automatic int unsigned shamt_mask(input int unsigned width);
        return width - 1;
    endfunction

    function automatic logic is_shift_op(input ALU_Ops op);
        return (op == SllOp) || (op == SrlOp) || (op == SraOp);
    endfunction

endpackage

// File: rtl/alu_share_alu.sv
// ALU
//   Shared combinational ALU.
//   a_i, b_i : operands
//   op_i     : operation (ALU_Ops); unknown encodings produce 0
//   y_o      : result, wraps at DATA_WIDTH, no flags
module ALU
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  ALU_Ops                op_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0] shamt;

    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            AddOp:   y_o = a_i + b_i;
            SubOp:   y_o = a_i - b_i;
            AndOp:   y_o = a_i & b_i;
            OrOp:    y_o = a_i | b_i;
            XorOp:   y_o = a_i ^ b_i;
            SllOp:   y_o = a_i << shamt;
            SrlOp:   y_o = a_i >> shamt;
            SraOp:   y_o = $signed(a_i) >>> shamt;
            SltOp:   y_o = DATA_WIDTH'($signed(a_i) < $signed(b_i));
            SltuOp:  y_o = DATA_WIDTH'(a_i < b_i);
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : index with highest priority; scan goes upward and wraps
//   grant_o : one-hot grant (zero when no request)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share.sv
// alu_share
//   Shares one ALU between NUM_REQ requesters with round-robin arbitration
//   and valid/ready handshakes on both request and response side.
//   clk_i, reset_ni       : clock, async active-low reset
//   req_valid_i/ready_o   : request handshake per requester
//   req_a_i/b_i/op_i      : operands and operation per requester
//   resp_valid_o/ready_i  : response handshake per requester
//   resp_data_o           : registered result (shared)
//   grant_o               : one-hot owner of the current operation
//   busy_o                : high whenever not IDLE
//   Macro ALU_SHARE_B2B_EN: accept a new request in the response-handshake
//   cycle (2 cycles/op instead of 3).
//
//   state | meaning
//   IDLE  | no operation in progress, arbitration open
//   EXEC  | ALU evaluates the captured operands
//   RESP  | result held for the owner until it accepts
module alu_share
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
    input  ALU_Ops [NUM_REQ-1:0]                req_op_i,
    output logic [NUM_REQ-1:0]                  resp_valid_o,
    input  logic [NUM_REQ-1:0]                  resp_ready_i,
    output logic [DATA_WIDTH-1:0]               resp_data_o,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic                                busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ALU_SHARE_B2B_EN
    localparam bit B2B_EN = 1'b1;
`else
    localparam bit B2B_EN = 1'b0;
`endif

    ShareState              state;
    logic [PTR_W-1:0]       prio_ptr;
    logic [PTR_W-1:0]       owner;
    logic [PTR_W-1:0]       ptr_after_owner;
    logic [PTR_W-1:0]       arb_ptr;
    logic [PTR_W-1:0]       win_idx;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [DATA_WIDTH-1:0]  op_a;
    logic [DATA_WIDTH-1:0]  op_b;
    ALU_Ops                 op_code;
    logic [DATA_WIDTH-1:0]  sel_b;
    logic [DATA_WIDTH-1:0]  alu_y;
    logic                   accept_en;
    logic                   accept;
    logic                   resp_done;

    assign ptr_after_owner = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign resp_done       = (state == RESP) && resp_ready_i[owner];

    // In RESP the arbiter already looks one past the owner, so a
    // back-to-back acceptance sees the updated priority.
    assign arb_ptr = (state == RESP) ? ptr_after_owner : prio_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (arb_ptr),
        .grant_o (arb_grant)
    );

    always_comb begin
        accept_en = 1'b0;
        if (reset_ni) begin
            case (state)
                IDLE:    accept_en = 1'b1;
                RESP:    accept_en = B2B_EN && resp_ready_i[owner];
                default: accept_en = 1'b0;
            endcase
        end
    end

    assign req_ready_o = accept_en ? arb_grant : '0;
    assign accept      = |req_ready_o;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        sel_b = req_b_i[win_idx];
        if (is_shift_op(req_op_i[win_idx])) begin
            sel_b = sel_b & DATA_WIDTH'(shamt_mask(DATA_WIDTH));
        end
    end

    ALU #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a_i  (op_a),
        .b_i  (op_b),
        .op_i (op_code),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            prio_ptr     <= '0;
            owner        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= AddOp;
            resp_data_o  <= '0;
            resp_valid_o <= '0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= req_a_i[win_idx];
                        op_b    <= sel_b;
                        op_code <= req_op_i[win_idx];
                        grant_o <= arb_grant;
                        owner   <= win_idx;
                        busy_o  <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_o  <= alu_y;
                    resp_valid_o <= grant_o;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        prio_ptr     <= ptr_after_owner;
                        resp_valid_o <= '0;
                        if (accept) begin
                            op_a    <= req_a_i[win_idx];
                            op_b    <= sel_b;
                            op_code <= req_op_i[win_idx];
                            grant_o <= arb_grant;
                            owner   <= win_idx;
                            state   <= EXEC;
                        end else begin
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    resp_valid_o <= '0;
                    grant_o      <= '0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share.sv
// tb_alu_share
//   Directed self-checking bench for alu_share (DATA_WIDTH=32, NUM_REQ=2).
//   Follows ALU_SHARE_B2B_EN to pick the expected op period.
module tb_alu_share;
    import alu_share_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
`ifdef ALU_SHARE_B2B_EN
    localparam int  OP_CYC = 2;
    localparam bit  B2B    = 1'b1;
`else
    localparam int  OP_CYC = 3;
    localparam bit  B2B    = 1'b0;
`endif

    logic                   clk_i = 1'b0;
    logic                   reset_ni;
    logic [NR-1:0]          req_valid_i;
    logic [NR-1:0]          req_ready_o;
    logic [NR-1:0][DW-1:0]  req_a_i;
    logic [NR-1:0][DW-1:0]  req_b_i;
    ALU_Ops [NR-1:0]        req_op_i;
    logic [NR-1:0]          resp_valid_o;
    logic [NR-1:0]          resp_ready_i;
    logic [DW-1:0]          resp_data_o;
    logic [NR-1:0]          grant_o;
    logic                   busy_o;

    int n_vec  = 0;
    int n_miss = 0;

    alu_share #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_op_i     (req_op_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Runs one isolated operation by requester idx and returns what was seen in RESP.
    task automatic do_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input ALU_Ops op, output logic [DW-1:0] data, output logic [NR-1:0] rv);
        int cyc;
        @(negedge clk_i);
        req_valid_i[idx] = 1'b1;
        req_a_i[idx]     = a;
        req_b_i[idx]     = b;
        req_op_i[idx]    = op;
        resp_ready_i     = '0;
        #1;
        cyc = 0;
        while (!req_ready_o[idx] && cyc < 8) begin
            @(negedge clk_i); #1; cyc++;
        end
        @(negedge clk_i);
        req_valid_i[idx] = 1'b0;
        @(negedge clk_i); #1;
        data = resp_data_o;
        rv   = resp_valid_o;
        resp_ready_i[idx] = 1'b1;
        @(negedge clk_i);
        resp_ready_i = '0;
    endtask

    task automatic test_reset();
        reset_ni     = 1'b0;
        req_valid_i  = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        req_op_i     = {AddOp, AddOp};
        resp_ready_i = '0;
        #2;
        n_vec++; if (resp_data_o !== 32'd0) begin n_miss++; $display("FAIL reset_data: got %0h expected 0", resp_data_o); end
        n_vec++; if (grant_o !== 2'b00) begin n_miss++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        n_vec++; if (resp_valid_o !== 2'b00) begin n_miss++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        req_valid_i = 2'b11;
        #1;
        n_vec++; if (req_ready_o !== 2'b00) begin n_miss++; $display("FAIL reset_ready: got %b expected 00", req_ready_o); end
        req_valid_i = '0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy_after: got %b expected 0", busy_o); end
    endtask

    task automatic test_single();
        @(negedge clk_i);
        req_valid_i = 2'b01;
        req_a_i[0]  = 32'd5;
        req_b_i[0]  = 32'd3;
        req_op_i[0] = AddOp;
        #1;
        n_vec++; if (req_ready_o !== 2'b01) begin n_miss++; $display("FAIL single_ready_c0: got %b expected 01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_vec++; if (resp_valid_o !== 2'b00) begin n_miss++; $display("FAIL single_valid_c1: got %b expected 00", resp_valid_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_miss++; $display("FAIL single_busy_c1: got %b expected 1", busy_o); end
        n_vec++; if (grant_o !== 2'b01) begin n_miss++; $display("FAIL single_grant_c1: got %b expected 01", grant_o); end
        @(negedge clk_i); #1;
        n_vec++; if (resp_valid_o !== 2'b01) begin n_miss++; $display("FAIL single_valid_c2: got %b expected 01", resp_valid_o); end
        n_vec++; if (resp_data_o !== 32'd8) begin n_miss++; $display("FAIL single_data_c2: got %0h expected 8", resp_data_o); end
        repeat (2) begin @(negedge clk_i); #1; end
        n_vec++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'd8) begin
            n_miss++; $display("FAIL single_hold: got valid %b data %0h expected 01 / 8", resp_valid_o, resp_data_o);
        end
        resp_ready_i = 2'b01;
        @(negedge clk_i);
        resp_ready_i = '0;
        #1;
        n_vec++; if (busy_o !== 1'b0 || grant_o !== 2'b00 || resp_valid_o !== 2'b00) begin
            n_miss++; $display("FAIL single_idle: got busy %b grant %b valid %b expected 0/00/00", busy_o, grant_o, resp_valid_o);
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] exp_g;
        logic [DW-1:0] exp_d;
        int cyc;
        @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        reset_ni = 1'b1;
        @(negedge clk_i);
        req_a_i[0] = 32'd10;   req_b_i[0] = 32'd4;    req_op_i[0] = SubOp;
        req_a_i[1] = 32'hF0;   req_b_i[1] = 32'h0F;   req_op_i[1] = XorOp;
        req_valid_i  = 2'b11;
        resp_ready_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (k % 2 == 0) ? 32'd6 : 32'hFF;
            cyc = 0;
            while (req_ready_o == 2'b00 && cyc < 8) begin
                @(negedge clk_i); #1; cyc++;
            end
            n_vec++; if (req_ready_o !== exp_g) begin n_miss++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, req_ready_o, exp_g); end
            @(negedge clk_i); #1;
            n_vec++; if (grant_o !== exp_g) begin n_miss++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, grant_o, exp_g); end
            @(negedge clk_i);
            if (k == 3) req_valid_i = '0;
            #1;
            n_vec++; if (resp_valid_o !== exp_g || resp_data_o !== exp_d) begin
                n_miss++; $display("FAIL contention_resp[%0d]: got %b/%0h expected %b/%0h", k, resp_valid_o, resp_data_o, exp_g, exp_d);
            end
        end
        @(negedge clk_i);
        resp_ready_i = '0;
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL contention_idle: got %b expected 0", busy_o); end
    endtask

    task automatic test_shift();
        logic [DW-1:0] d;
        logic [NR-1:0] rv;
        do_op(0, 32'h8000_0000, 32'h0000_0021, SraOp, d, rv);
        n_vec++; if (d !== 32'hC000_0000 || rv !== 2'b01) begin n_miss++; $display("FAIL shift_sra: got %0h/%b expected c0000000/01", d, rv); end
        do_op(1, 32'h0000_0001, 32'h0000_0020, SllOp, d, rv);
        n_vec++; if (d !== 32'h0000_0001 || rv !== 2'b10) begin n_miss++; $display("FAIL shift_sll: got %0h/%b expected 1/10", d, rv); end
        do_op(1, 32'hF000_0000, 32'h0000_0024, SrlOp, d, rv);
        n_vec++; if (d !== 32'h0F00_0000) begin n_miss++; $display("FAIL shift_srl: got %0h expected f000000", d); end
        do_op(0, 32'h0000_0010, 32'h0000_0021, AddOp, d, rv);
        n_vec++; if (d !== 32'h0000_0031) begin n_miss++; $display("FAIL add_unmasked: got %0h expected 31", d); end
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, AddOp, d, rv);
        n_vec++; if (d !== 32'h0000_0000) begin n_miss++; $display("FAIL add_wrap: got %0h expected 0", d); end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk_i);
        req_valid_i = 2'b01;
        req_a_i[0] = 32'd7; req_b_i[0] = 32'd9; req_op_i[0] = AddOp;
        @(negedge clk_i);
        req_valid_i = '0;
        @(negedge clk_i);
        req_valid_i  = 2'b10;
        req_a_i[1]   = 32'h0F00; req_b_i[1] = 32'h00F0; req_op_i[1] = OrOp;
        resp_ready_i = 2'b10;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (resp_data_o !== 32'd16 || resp_valid_o !== 2'b01) begin
                n_miss++; $display("FAIL bp_hold[%0d]: got %0h/%b expected 10/01", i, resp_data_o, resp_valid_o);
            end
            n_vec++; if (req_ready_o !== 2'b00) begin n_miss++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready_o); end
            @(negedge clk_i); #1;
        end
        n_vec++; if (busy_o !== 1'b1) begin n_miss++; $display("FAIL bp_busy: got %b expected 1", busy_o); end
        resp_ready_i = 2'b11;
        #1;
        n_vec++; if (req_ready_o !== (B2B ? 2'b10 : 2'b00)) begin
            n_miss++; $display("FAIL bp_handshake_ready: got %b expected %b", req_ready_o, (B2B ? 2'b10 : 2'b00));
        end
        cyc = 0;
        while (!req_ready_o[1] && cyc < 8) begin
            @(negedge clk_i); #1; cyc++;
        end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_vec++; if (grant_o !== 2'b10) begin n_miss++; $display("FAIL bp_grant1: got %b expected 10", grant_o); end
        @(negedge clk_i); #1;
        n_vec++; if (resp_data_o !== 32'h0FF0 || resp_valid_o !== 2'b10) begin
            n_miss++; $display("FAIL bp_resp1: got %0h/%b expected ff0/10", resp_data_o, resp_valid_o);
        end
        @(negedge clk_i);
        resp_ready_i = '0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic [NR-1:0] rv;
        do_op(0, 32'd1, 32'd2, AddOp, d, rv);
        n_vec++; if (d !== 32'd3) begin n_miss++; $display("FAIL rmid_pre: got %0h expected 3", d); end
        @(negedge clk_i);
        req_valid_i = 2'b10;
        req_a_i[1] = 32'd100; req_b_i[1] = 32'd1; req_op_i[1] = AddOp;
        #1;
        n_vec++; if (req_ready_o !== 2'b10) begin n_miss++; $display("FAIL rmid_accept: got %b expected 10", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_vec++; if (busy_o !== 1'b1) begin n_miss++; $display("FAIL rmid_exec: got %b expected 1", busy_o); end
        reset_ni = 1'b0;
        #1;
        n_vec++; if (busy_o !== 1'b0 || grant_o !== 2'b00 || resp_valid_o !== 2'b00 || resp_data_o !== 32'd0) begin
            n_miss++; $display("FAIL rmid_outputs: got busy %b grant %b valid %b data %0h expected all 0", busy_o, grant_o, resp_valid_o, resp_data_o);
        end
        req_valid_i = 2'b11;
        req_a_i[0] = 32'd9; req_b_i[0] = 32'd2; req_op_i[0] = SubOp;
        #1;
        n_vec++; if (req_ready_o !== 2'b00) begin n_miss++; $display("FAIL rmid_ready_in_reset: got %b expected 00", req_ready_o); end
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        n_vec++; if (req_ready_o !== 2'b01) begin n_miss++; $display("FAIL rmid_prio0: got %b expected 01", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        @(negedge clk_i); #1;
        n_vec++; if (resp_valid_o !== 2'b01 || resp_data_o !== 32'd7) begin
            n_miss++; $display("FAIL rmid_resp: got %b/%0h expected 01/7", resp_valid_o, resp_data_o);
        end
        resp_ready_i = 2'b01;
        @(negedge clk_i);
        resp_ready_i = '0;
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] exp_g;
        int cyc;
        @(negedge clk_i);
        req_a_i[0] = 32'hFF;  req_b_i[0] = 32'h0F; req_op_i[0] = AndOp;
        req_a_i[1] = 32'h30;  req_b_i[1] = 32'h03; req_op_i[1] = OrOp;
        req_valid_i  = 2'b11;
        resp_ready_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            cyc = 0;
            while (req_ready_o == 2'b00 && cyc < 8) begin
                @(negedge clk_i); #1; cyc++;
            end
            n_vec++; if (req_ready_o !== exp_g) begin n_miss++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, req_ready_o, exp_g); end
            if (k > 0) begin
                n_vec++; if (cyc + 2 != OP_CYC) begin n_miss++; $display("FAIL b2b_period[%0d]: got %0d cycles expected %0d", k, cyc + 2, OP_CYC); end
            end
            @(negedge clk_i); #1;
            @(negedge clk_i);
            if (k == 3) req_valid_i = '0;
            #1;
            n_vec++; if (resp_data_o !== ((k % 2 == 0) ? 32'h33 : 32'h0F)) begin
                n_miss++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, resp_data_o, ((k % 2 == 0) ? 32'h33 : 32'h0F));
            end
        end
        @(negedge clk_i);
        resp_ready_i = '0;
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL b2b_idle: got %b expected 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_shift();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
